bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between two requesters, e.g. I-cache refill and D-cache refill/writeback in the memory hierarchy.
- Each requester uses a valid/ready request handshake and receives a single-cycle response pulse.
- Arbitration is round-robin, with an optional lock so a requester can hold the port for a multi-beat line transfer.
- The block drives the RAM port's we/address/data_in and steers the registered data_out (1-cycle read latency) back to the winning requester.

Parameters:
- DATA_WIDTH, 32, width of data words on requesters and RAM port
- ADDR_WIDTH, 32, width of word addresses on requesters and RAM port

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_lock  in  1  keep grant after this beat
- req0_addr  in  ADDR_WIDTH  word address
- req0_wdata  in  DATA_WIDTH  write data
- rsp0_valid  out  1  response pulse for requester 0
- rsp0_rdata  out  DATA_WIDTH  read data (valid with rsp0_valid for reads)
- req1_valid, req1_ready, req1_we, req1_lock, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: identical to the requester 0 ports, for requester 1
- bram_we  out  1  to RAM port we
- bram_address  out  ADDR_WIDTH  to RAM port address
- bram_data_in  out  DATA_WIDTH  to RAM port data_in
- bram_data_out  in  DATA_WIDTH  from RAM port data_out (registered, valid 1 cycle after address)

Behaviour:
- Reset (reset_n=0, asynchronous): rsp0_valid=rsp1_valid=0, rspN_rdata=0, bram_we=0, bram_address=0, bram_data_in=0, req0_ready=req1_ready=0. Priority pointer = requester 0. Lock owner = none. Pending-response register cleared.
- Any in-flight response is dropped on reset.
- Grant (combinational, each cycle):
  - If lock owner X is set and reqX_valid=1, X wins.
  - If lock owner X is set and reqX_valid=0, no grant that cycle; the lock is held and the other requester is stalled.
  - Otherwise, if one requester is valid it wins.
  - If both are valid, the priority-pointer requester wins.
- reqN_ready = grant to N. At most one ready per cycle. A beat is accepted when valid && ready.
- RAM drive is combinational from the winner: bram_we = winner_we & accepted; bram_address/bram_data_in = winner addr/wdata.
- With no grant: bram_we=0 and bram_address/bram_data_in hold their last values (no spurious writes).
- On acceptance:
  - Priority pointer moves to the other requester.
  - If winner_lock=1, lock owner = winner; if winner_lock=0, lock is cleared.
  - A pending tag {valid, id, is_read} is registered.
- Response, exactly 1 cycle after acceptance:
  - rspID_valid=1 for one cycle.
  - For reads, rspID_rdata = bram_data_out. For writes, rdata = 0 (write ack only).
  - The other requester's rsp stays 0.
  - Throughput is one beat per cycle; back-to-back beats produce back-to-back responses.
- Read-during-write on the same address through this port returns the old data (RAM semantics); the arbiter does not forward.
- Requesters must hold addr/we/wdata/lock stable while valid && !ready.
- The other RAM port is outside this block; cross-port same-address collisions are the system's responsibility.

Test Plan:
- Single read: RAM[0x10]=0xDEADBEEF; req0 read addr 0x10 → req0_ready same cycle, bram_we=0, next cycle rsp0_valid=1 with rsp0_rdata=0xDEADBEEF, rsp1_valid=0.
- Write then read: req1 write 0x20←0x12345678, then read 0x20 on the next cycle → write ack pulse (rdata=0), then rsp1_rdata=0x12345678.
- Contention: both valid reading 0x1 and 0x2 for 4 cycles after reset → grants alternate 0,1,0,1; responses alternate accordingly, each one cycle after its grant.
- Lock burst: req0 issues 4 reads (addr 0x40..0x43) with lock=1,1,1,0 while req1 is continuously valid → req1_ready=0 until after the 4th beat, then req1 is granted; a req0 valid gap mid-burst stalls both requesters.
- Reset mid-operation: assert reset_n=0 the cycle after a read acceptance → rsp0_valid stays 0, all outputs 0; after release, the first contended grant goes to requester 0.
- Idle: no valid for 10 cycles → bram_we=0 throughout, no rsp pulses.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for one block-RAM port, with a lock that
// lets the current owner keep the port for a multi-beat line transfer.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_address,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out
);

  logic                  r_ptr;
  logic                  r_lock_valid;
  logic                  r_lock_id;
  logic                  r_pend_valid;
  logic                  r_pend_id;
  logic                  r_pend_read;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_data_hold;

  logic                  w_grant_valid;
  logic                  w_grant_id;
  logic                  w_win_we;
  logic                  w_win_lock;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  // Grant selection; a lock owner that drops valid idles the port instead of yielding it.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = 1'b0;
    if (!reset_n) begin
      w_grant_valid = 1'b0;
      w_grant_id    = 1'b0;
    end else if (r_lock_valid) begin
      w_grant_id    = r_lock_id;
      w_grant_valid = r_lock_id ? req1_valid : req0_valid;
    end else if (req0_valid && req1_valid) begin
      w_grant_valid = 1'b1;
      w_grant_id    = r_ptr;
    end else if (req0_valid) begin
      w_grant_valid = 1'b1;
      w_grant_id    = 1'b0;
    end else if (req1_valid) begin
      w_grant_valid = 1'b1;
      w_grant_id    = 1'b1;
    end else begin
      w_grant_valid = 1'b0;
      w_grant_id    = 1'b0;
    end
  end

  // Winner request fields.
  always_comb begin
    if (w_grant_id) begin
      w_win_we    = req1_we;
      w_win_lock  = req1_lock;
      w_win_addr  = req1_addr;
      w_win_wdata = req1_wdata;
    end else begin
      w_win_we    = req0_we;
      w_win_lock  = req0_lock;
      w_win_addr  = req0_addr;
      w_win_wdata = req0_wdata;
    end
  end

  assign req0_ready   = w_grant_valid & ~w_grant_id;
  assign req1_ready   = w_grant_valid &  w_grant_id;
  assign bram_we      = w_grant_valid & w_win_we;
  // Address and data hold their last value while idle so the RAM sees no glitching bus.
  assign bram_address = w_grant_valid ? w_win_addr  : r_addr_hold;
  assign bram_data_in = w_grant_valid ? w_win_wdata : r_data_hold;

  // Arbitration state: round-robin pointer, lock owner and the last driven address/data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= 1'b0;
      r_lock_valid <= 1'b0;
      r_lock_id    <= 1'b0;
      r_addr_hold  <= {ADDR_WIDTH{1'b0}};
      r_data_hold  <= {DATA_WIDTH{1'b0}};
    end else if (w_grant_valid) begin
      r_ptr        <= ~w_grant_id;
      r_lock_valid <= w_win_lock;
      r_lock_id    <= w_grant_id;
      r_addr_hold  <= w_win_addr;
      r_data_hold  <= w_win_wdata;
    end else begin
      r_ptr        <= r_ptr;
      r_lock_valid <= r_lock_valid;
      r_lock_id    <= r_lock_id;
      r_addr_hold  <= r_addr_hold;
      r_data_hold  <= r_data_hold;
    end
  end

  // Pending-response tag, lined up with the RAM's one-cycle read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_id    <= 1'b0;
      r_pend_read  <= 1'b0;
    end else if (w_grant_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_id    <= w_grant_id;
      r_pend_read  <= ~w_win_we;
    end else begin
      r_pend_valid <= 1'b0;
      r_pend_id    <= r_pend_id;
      r_pend_read  <= r_pend_read;
    end
  end

  assign rsp0_valid = r_pend_valid & ~r_pend_id;
  assign rsp1_valid = r_pend_valid &  r_pend_id;
  // Writes are acknowledged with zero data; only reads carry RAM output.
  assign rsp0_rdata = (rsp0_valid && r_pend_read) ? bram_data_out : {DATA_WIDTH{1'b0}};
  assign rsp1_rdata = (rsp1_valid && r_pend_read) ? bram_data_out : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and RAM contents.
module tb_bram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        bram_we;
  logic [31:0] bram_address, bram_data_in, bram_data_out;

  int tests = 0;
  int failed = 0;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];

  // model state
  int          m_ptr, m_lock, m_pid;
  logic        m_pv, m_pread;
  logic [31:0] m_pdata, m_last_addr, m_last_data;

  bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bram_we(bram_we), .bram_address(bram_address), .bram_data_in(bram_data_in),
    .bram_data_out(bram_data_out)
  );

  always #5 clock = ~clock;

  // RAM with registered output and read-old-data behaviour
  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bram_we) ram[bram_address[7:0]] <= bram_data_in;
    bram_data_out <= ram[bram_address[7:0]];
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = 32'd0; req1_wdata = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    m_ptr = 0; m_lock = -1; m_pv = 1'b0; m_pid = 0; m_pread = 1'b0;
    m_pdata = 32'd0; m_last_addr = 32'd0; m_last_data = 32'd0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clock);
    #1 pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h33; req0_wdata = 32'hFFFF_FFFF;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b0) begin failed++; $display("FAIL reset_ready0 got %0b exp 0", req0_ready); end
    tests++; if (bram_we !== 1'b0) begin failed++; $display("FAIL reset_we got %0b exp 0", bram_we); end
    tests++; if (bram_address !== 32'd0) begin failed++; $display("FAIL reset_addr got %h exp 0", bram_address); end
    tests++; if (bram_data_in !== 32'd0) begin failed++; $display("FAIL reset_din got %h exp 0", bram_data_in); end
    tests++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin failed++; $display("FAIL reset_rsp got %b exp 00", {rsp0_valid, rsp1_valid}); end
    tests++; if ({rsp0_rdata, rsp1_rdata} !== 64'd0) begin failed++; $display("FAIL reset_rdata got %h exp 0", {rsp0_rdata, rsp1_rdata}); end
    do_reset();
  endtask

  task automatic test_single_read();
    preload(8'h10, 32'hDEAD_BEEF);
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h10;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b1) begin failed++; $display("FAIL single_ready0 got %0b exp 1", req0_ready); end
    tests++; if (bram_we !== 1'b0) begin failed++; $display("FAIL single_we got %0b exp 0", bram_we); end
    tests++; if (bram_address !== 32'h10) begin failed++; $display("FAIL single_addr got %h exp 10", bram_address); end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    tests++; if (rsp0_valid !== 1'b1) begin failed++; $display("FAIL single_rsp0 got %0b exp 1", rsp0_valid); end
    tests++; if (rsp0_rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL single_rdata got %h exp deadbeef", rsp0_rdata); end
    tests++; if (rsp1_valid !== 1'b0) begin failed++; $display("FAIL single_rsp1 got %0b exp 0", rsp1_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_write_read();
    do_reset();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h1234_5678;
    @(negedge clock);
    tests++; if ({req0_ready, req1_ready} !== 2'b01) begin failed++; $display("FAIL wr_ready got %b exp 01", {req0_ready, req1_ready}); end
    tests++; if (bram_we !== 1'b1) begin failed++; $display("FAIL wr_we got %0b exp 1", bram_we); end
    tests++; if (bram_data_in !== 32'h1234_5678) begin failed++; $display("FAIL wr_din got %h exp 12345678", bram_data_in); end
    @(posedge clock); #1 req1_we = 1'b0;
    @(negedge clock);
    tests++; if (req1_ready !== 1'b1) begin failed++; $display("FAIL rd_ready1 got %0b exp 1", req1_ready); end
    tests++; if (bram_we !== 1'b0) begin failed++; $display("FAIL rd_we got %0b exp 0", bram_we); end
    tests++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'd0) begin failed++; $display("FAIL wr_ack got v=%0b d=%h exp v=1 d=0", rsp1_valid, rsp1_rdata); end
    tests++; if (rsp0_valid !== 1'b0) begin failed++; $display("FAIL wr_rsp0 got %0b exp 0", rsp0_valid); end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    tests++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h1234_5678) begin failed++; $display("FAIL rd_data got v=%0b d=%h exp v=1 d=12345678", rsp1_valid, rsp1_rdata); end
    @(posedge clock); #1;
  endtask

  task automatic test_contention();
    logic [31:0] exp_d;
    preload(8'h01, 32'h1111_0001);
    preload(8'h02, 32'h2222_0002);
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h1;
    req1_valid = 1'b1; req1_addr = 32'h2;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle_inputs();
      @(negedge clock);
      if (k < 4) begin
        tests++;
        if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
          failed++; $display("FAIL contend_grant k=%0d got %b exp %b", k, {req0_ready, req1_ready}, {k % 2 == 0, k % 2 == 1});
        end
      end
      if (k > 0) begin
        exp_d = ((k - 1) % 2 == 0) ? 32'h1111_0001 : 32'h2222_0002;
        tests++;
        if (rsp0_valid !== ((k - 1) % 2 == 0) || rsp1_valid !== ((k - 1) % 2 == 1)) begin
          failed++; $display("FAIL contend_rsp k=%0d got %b", k, {rsp0_valid, rsp1_valid});
        end
        tests++;
        if ((rsp0_valid ? rsp0_rdata : rsp1_rdata) !== exp_d) begin
          failed++; $display("FAIL contend_data k=%0d got %h exp %h", k, rsp0_valid ? rsp0_rdata : rsp1_rdata, exp_d);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lock_burst();
    int v0s [7] = '{1, 1, 0, 1, 1, 0, 0};
    int r1s [7] = '{0, 0, 0, 0, 0, 1, 0};
    int b = 0;
    int prev = -1;
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 32'h4000_0000 + 32'(i));
    preload(8'h50, 32'h5050_5050);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req0_valid = (v0s[c] != 0); req0_addr = 32'h40 + 32'(b); req0_lock = (b < 3);
      req1_valid = (c <= 5); req1_addr = 32'h50;
      @(negedge clock);
      tests++;
      if (req0_ready !== (v0s[c] != 0) || req1_ready !== (r1s[c] != 0)) begin
        failed++; $display("FAIL lock_grant c=%0d got %b exp %b", c, {req0_ready, req1_ready}, {v0s[c] != 0, r1s[c] != 0});
      end
      tests++;
      if (rsp0_valid !== (prev >= 0) || (prev >= 0 && rsp0_rdata !== 32'h4000_0000 + 32'(prev))) begin
        failed++; $display("FAIL lock_rsp0 c=%0d got v=%0b d=%h exp beat %0d", c, rsp0_valid, rsp0_rdata, prev);
      end
      if (c == 2) begin
        tests++;
        if (bram_we !== 1'b0 || bram_address !== 32'h41) begin
          failed++; $display("FAIL lock_gap_hold got we=%0b a=%h exp we=0 a=41", bram_we, bram_address);
        end
      end
      if (c == 6) begin
        tests++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h5050_5050) begin
          failed++; $display("FAIL lock_rsp1 got v=%0b d=%h exp v=1 d=50505050", rsp1_valid, rsp1_rdata);
        end
      end
      prev = (v0s[c] != 0) ? b : -1;
      if (v0s[c] != 0) b++;
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h10;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b1) begin failed++; $display("FAIL rstmid_ready0 got %0b exp 1", req0_ready); end
    @(posedge clock); #1 reset_n = 1'b0; req1_valid = 1'b1; req1_addr = 32'h2;
    @(negedge clock);
    tests++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 32'd0) begin failed++; $display("FAIL rstmid_rsp0 got v=%0b d=%h exp 0", rsp0_valid, rsp0_rdata); end
    tests++; if ({req0_ready, req1_ready, bram_we} !== 3'b000) begin failed++; $display("FAIL rstmid_ctl got %b exp 000", {req0_ready, req1_ready, bram_we}); end
    tests++; if (bram_address !== 32'd0) begin failed++; $display("FAIL rstmid_addr got %h exp 0", bram_address); end
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin failed++; $display("FAIL rstmid_ptr got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clock); #1 idle_inputs();
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      tests++;
      if ({bram_we, rsp0_valid, rsp1_valid} !== 3'b000) begin
        failed++; $display("FAIL idle c=%0d got we/rsp0/rsp1=%b exp 000", c, {bram_we, rsp0_valid, rsp1_valid});
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    logic        v [2], we [2], lk [2], hold [2];
    logic [31:0] ad [2], wd [2];
    int          win;
    logic        e_we, e_r0, e_r1;
    logic [31:0] e_addr, e_din, e_d0, e_d1;
    for (int i = 0; i < 16; i++) preload(8'(i), $urandom());
    do_reset();
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold[0]) begin
        req0_valid = ($urandom_range(0, 3) != 0); req0_we = 1'($urandom_range(0, 1));
        req0_lock = ($urandom_range(0, 2) == 0); req0_addr = 32'($urandom_range(0, 15)); req0_wdata = $urandom();
      end
      if (!hold[1]) begin
        req1_valid = ($urandom_range(0, 3) != 0); req1_we = 1'($urandom_range(0, 1));
        req1_lock = ($urandom_range(0, 2) == 0); req1_addr = 32'($urandom_range(0, 15)); req1_wdata = $urandom();
      end
      @(negedge clock);
      v[0] = req0_valid; we[0] = req0_we; lk[0] = req0_lock; ad[0] = req0_addr; wd[0] = req0_wdata;
      v[1] = req1_valid; we[1] = req1_we; lk[1] = req1_lock; ad[1] = req1_addr; wd[1] = req1_wdata;
      if (m_lock >= 0) win = v[m_lock] ? m_lock : -1;
      else if (v[0] && v[1]) win = m_ptr;
      else if (v[0]) win = 0;
      else if (v[1]) win = 1;
      else win = -1;
      e_we   = (win >= 0) ? we[win] : 1'b0;
      e_addr = (win >= 0) ? ad[win] : m_last_addr;
      e_din  = (win >= 0) ? wd[win] : m_last_data;
      e_r0   = m_pv && (m_pid == 0);
      e_r1   = m_pv && (m_pid == 1);
      e_d0   = (e_r0 && m_pread) ? m_pdata : 32'd0;
      e_d1   = (e_r1 && m_pread) ? m_pdata : 32'd0;
      tests++; if (req0_ready !== (win == 0)) begin failed++; $display("FAIL rnd_ready0 c=%0d got %0b exp %0b", c, req0_ready, win == 0); end
      tests++; if (req1_ready !== (win == 1)) begin failed++; $display("FAIL rnd_ready1 c=%0d got %0b exp %0b", c, req1_ready, win == 1); end
      tests++; if (bram_we !== e_we) begin failed++; $display("FAIL rnd_we c=%0d got %0b exp %0b", c, bram_we, e_we); end
      tests++; if (bram_address !== e_addr) begin failed++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, bram_address, e_addr); end
      tests++; if (bram_data_in !== e_din) begin failed++; $display("FAIL rnd_din c=%0d got %h exp %h", c, bram_data_in, e_din); end
      tests++; if (rsp0_valid !== e_r0 || rsp0_rdata !== e_d0) begin failed++; $display("FAIL rnd_rsp0 c=%0d got %0b/%h exp %0b/%h", c, rsp0_valid, rsp0_rdata, e_r0, e_d0); end
      tests++; if (rsp1_valid !== e_r1 || rsp1_rdata !== e_d1) begin failed++; $display("FAIL rnd_rsp1 c=%0d got %0b/%h exp %0b/%h", c, rsp1_valid, rsp1_rdata, e_r1, e_d1); end
      if (win >= 0) begin
        m_ptr = 1 - win;
        m_lock = lk[win] ? win : -1;
        m_pv = 1'b1; m_pid = win; m_pread = ~we[win];
        m_pdata = ref_mem[ad[win][7:0]];
        if (we[win]) ref_mem[ad[win][7:0]] = wd[win];
        m_last_addr = ad[win]; m_last_data = wd[win];
      end else begin
        m_pv = 1'b0;
      end
      hold[0] = v[0] && (win != 0);
      hold[1] = v[1] && (win != 1);
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_lock_burst();
    test_reset_mid();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
